// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: RV opcodes that bypass the ALU,
// load funct3 encodings and the stage FSM state encoding.
package wb_pkg;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic {
    RUN       = 1'b0,
    WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_ext.sv
// Combinational load lane extraction: shifts the raw aligned word down by the
// byte offset, then sign- or zero-extends the selected byte/half/word.
module load_ext
  import wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OFFW = $clog2(XLEN/8)
) (
  input  logic [2:0]      funct3,
  input  logic [OFFW-1:0] addr_lo,
  input  logic [XLEN-1:0] raw_data,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0] lane;

  always_comb begin
    lane = raw_data >> {addr_lo, 3'b000};
    case (funct3)
      F3_LB:   load_data = XLEN'($signed(lane[7:0]));
      F3_LH:   load_data = XLEN'($signed(lane[15:0]));
      F3_LW:   load_data = XLEN'($signed(lane[31:0]));
      F3_LBU:  load_data = XLEN'(lane[7:0]);
      F3_LHU:  load_data = XLEN'(lane[15:0]);
      F3_LWU:  load_data = XLEN'(lane[31:0]);
      // LD; on RV32 the full lane is the word, so 011 degenerates to LW
      default: load_data = lane;
    endcase
  end

endmodule

// File: rtl/wb_pipe_stage.sv
// Writeback stage: picks the retiring result and drives a registered RF write port;
// late loads park in WAIT_LOAD. Define WB_RETIRE_CNT_EN to add the 64-bit retire_cnt output.
//
// state     | meaning
// RUN       | ready for a new instruction (in_ready=1)
// WAIT_LOAD | load accepted without data, waiting for mem_rsp_valid
module wb_pipe_stage
  import wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OFFW = $clog2(XLEN/8)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_write,
  input  logic            in_mem_to_reg,
  input  logic [XLEN-1:0] in_pc_plus_imm,
  input  logic [XLEN-1:0] in_pc_plus_four,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_alu_data,
  input  logic [OFFW-1:0] in_addr_lo,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]     retire_cnt
`endif
);

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_to_reg;
    logic [XLEN-1:0] pc_plus_imm;
    logic [XLEN-1:0] pc_plus_four;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] alu_data;
    logic [OFFW-1:0] addr_lo;
  } instr_t;

  wb_state_e       state_q, state_d;
  instr_t          hold_q, hold_d, in_instr, cur;
  logic            accept, cmplt;
  logic [XLEN-1:0] load_data, result;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  always_comb begin
    in_instr.opcode       = in_opcode;
    in_instr.funct3       = in_funct3;
    in_instr.rd           = in_rd;
    in_instr.reg_write    = in_reg_write;
    in_instr.mem_to_reg   = in_mem_to_reg;
    in_instr.pc_plus_imm  = in_pc_plus_imm;
    in_instr.pc_plus_four = in_pc_plus_four;
    in_instr.imm          = in_imm;
    in_instr.alu_data     = in_alu_data;
    in_instr.addr_lo      = in_addr_lo;
  end

  // In RUN the retiring instruction is the one on the inputs; in WAIT_LOAD it is the held load.
  assign cur      = (state_q == RUN) ? in_instr : hold_q;
  assign in_ready = (state_q == RUN);
  assign accept   = in_valid & in_ready;

  load_ext #(.XLEN(XLEN), .OFFW(OFFW)) u_load_ext (
    .funct3    (cur.funct3),
    .addr_lo   (cur.addr_lo),
    .raw_data  (mem_rsp_data),
    .load_data (load_data)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cmplt   = 1'b0;
    case (state_q)
      RUN: begin
        if (accept) begin
          hold_d = in_instr;
          if (!in_mem_to_reg || mem_rsp_valid) cmplt   = 1'b1;
          else                                 state_d = WAIT_LOAD;
        end
      end
      WAIT_LOAD: begin
        if (mem_rsp_valid) begin
          cmplt   = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    if (cur.opcode == OP_LUI)                              result = cur.imm;
    else if (cur.opcode == OP_AUIPC)                       result = cur.pc_plus_imm;
    else if (cur.opcode == OP_JAL || cur.opcode == OP_JALR) result = cur.pc_plus_four;
    else if (cur.mem_to_reg)                               result = load_data;
    else                                                   result = cur.alu_data;

    rf_we_d    = cmplt & cur.reg_write & (cur.rd != 5'd0);
    rf_waddr_d = rf_we_d ? cur.rd : rf_waddr_q;
    rf_wdata_d = rf_we_d ? result : rf_wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      hold_q     <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q, retire_cnt_d;

  assign retire_cnt_d = retire_cnt_q + 64'(cmplt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retire_cnt_q <= '0;
    else        retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule
